// File: rtl/io_port_pkg.sv
// io_port_pkg: shared constants and helpers for the I/O port responder.
//   - register byte offsets inside the I/O region
//   - active-low 7-segment patterns (bit0 = segment a) and the decode function
package io_port_pkg;

    localparam int NUM_KEYS = 3;
    localparam int NUM_HEX  = 6;
    localparam int SW_W     = 10;

    localparam logic [7:0] IO_SW_OFS        = 8'h00;
    localparam logic [7:0] IO_KEY_OFS       = 8'h04;
    localparam logic [7:0] IO_KEY_EVENT_OFS = 8'h08;
    localparam logic [7:0] IO_LED_OFS       = 8'h0C;
    localparam logic [7:0] IO_HEX_OFS       = 8'h10;
    localparam logic [7:0] IO_HEX_BLANK_OFS = 8'h14;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Index d holds the pattern for hex digit d (entry 15 listed first).
    localparam logic [15:0][6:0] SEG_PATTERNS = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        return SEG_PATTERNS[digit];
    endfunction

endpackage

// File: rtl/io_key_debounce.sv
// io_key_debounce: debounces one synchronized key level (1 = pressed) and
// emits a one-cycle rise pulse on the cycle the debounced level goes 0->1.
// Ports: clock, reset (sync, active-high), level_sync in; level_deb, rise out.
// Build option IO_KEY_DEBOUNCE_EN: when defined, a stability counter filters
// the level; when undefined, level_deb follows level_sync directly.
module io_key_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic level_sync,
    output logic level_deb,
    output logic rise
);

    if (DEBOUNCE_CYCLES < 1) begin : g_cfg_err
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    logic deb_prev;

`ifdef IO_KEY_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] cnt;
    logic             deb_q;

    // Counter runs only while the input disagrees with the debounced level;
    // any agreement restarts it, so short glitches never reach the flip.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt   <= '0;
            deb_q <= 1'b0;
        end else if (level_sync != deb_q) begin
            if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                deb_q <= level_sync;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end

    assign level_deb = deb_q;
`else
    assign level_deb = level_sync;
`endif

    always_ff @(posedge clock) begin
        if (reset) deb_prev <= 1'b0;
        else       deb_prev <= level_deb;
    end

    assign rise = level_deb & ~deb_prev;

endmodule

// File: rtl/io_port_responder.sv
// io_port_responder: memory-mapped I/O responder on the CPU data bus.
// Ports:
//   clock, reset        single clock, synchronous active-high reset
//   io_sel, wen, ren    access strobes (wen/ren only meaningful with io_sel)
//   addr, wdata         byte offset (bits [1:0] ignored) and store data
//   rdata, rvalid       registered load data, valid one cycle after request
//   sw, key[3:1]        raw asynchronous switches / active-low keys
//   hex5..hex0, led     active-low segment drive, active-high LEDs
// Registers: SW(RO) KEY(RO) KEY_EVENT(W1C) LED HEX HEX_BLANK.
// Build option IO_KEY_DEBOUNCE_EN enables the per-key debounce counters.
module io_port_responder
    import io_port_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ADDR_W          = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_sel,
    input  logic              wen,
    input  logic              ren,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              rvalid,
    input  logic [SW_W-1:0]   sw,
    input  logic [3:1]        key,
    output logic [6:0]        hex5,
    output logic [6:0]        hex4,
    output logic [6:0]        hex3,
    output logic [6:0]        hex2,
    output logic [6:0]        hex1,
    output logic [6:0]        hex0,
    output logic [SW_W-1:0]   led
);

    // ---------------- input synchronizers ----------------
    logic [SW_W-1:0]     sw_s1, sw_s2;
    logic [NUM_KEYS-1:0] key_s1, key_s2;

    always_ff @(posedge clock) begin
        if (reset) begin
            sw_s1  <= '0;
            sw_s2  <= '0;
            key_s1 <= '1;
            key_s2 <= '1;
        end else begin
            sw_s1  <= sw;
            sw_s2  <= sw_s1;
            key_s1 <= key;
            key_s2 <= key_s1;
        end
    end

    // ---------------- key debounce, one instance per key ----------------
    logic [NUM_KEYS-1:0] key_lvl, key_deb, key_rise;

    assign key_lvl = ~key_s2;

    io_key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_deb [NUM_KEYS-1:0] (
        .clock     (clock),
        .reset     (reset),
        .level_sync(key_lvl),
        .level_deb (key_deb),
        .rise      (key_rise)
    );

    // ---------------- bus decode ----------------
    logic [ADDR_W-1:0] word;
    logic              wr, rd;
    logic              unused_bits;

    assign word        = {addr[ADDR_W-1:2], 2'b00};
    assign wr          = io_sel & wen;
    assign rd          = io_sel & ren;
    assign unused_bits = ^{addr[1:0], wdata[31:24]};

    logic [SW_W-1:0]      led_q;
    logic [4*NUM_HEX-1:0] hex_q;
    logic [NUM_HEX-1:0]   blank_q;
    logic [NUM_KEYS-1:0]  event_q;
    logic [NUM_KEYS-1:0]  event_clr;
    logic [31:0]          rd_mux;

    always_comb begin
        rd_mux = '0;
        case (word)
            ADDR_W'(IO_SW_OFS):        rd_mux = {22'b0, sw_s2};
            ADDR_W'(IO_KEY_OFS):       rd_mux = {29'b0, key_deb};
            ADDR_W'(IO_KEY_EVENT_OFS): rd_mux = {29'b0, event_q};
            ADDR_W'(IO_LED_OFS):       rd_mux = {22'b0, led_q};
            ADDR_W'(IO_HEX_OFS):       rd_mux = {8'b0, hex_q};
            ADDR_W'(IO_HEX_BLANK_OFS): rd_mux = {26'b0, blank_q};
            default:                   rd_mux = '0;
        endcase
    end

    assign event_clr = (wr && word == ADDR_W'(IO_KEY_EVENT_OFS)) ? wdata[NUM_KEYS-1:0] : '0;

    // Read data is taken from pre-write register values, so a same-cycle
    // store is not visible to the load. A new rise beats a same-cycle clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata   <= '0;
            rvalid  <= 1'b0;
            led_q   <= '0;
            hex_q   <= '0;
            blank_q <= '1;
            event_q <= '0;
        end else begin
            rvalid  <= rd;
            if (rd) rdata <= rd_mux;
            if (wr && word == ADDR_W'(IO_LED_OFS))       led_q   <= wdata[SW_W-1:0];
            if (wr && word == ADDR_W'(IO_HEX_OFS))       hex_q   <= wdata[4*NUM_HEX-1:0];
            if (wr && word == ADDR_W'(IO_HEX_BLANK_OFS)) blank_q <= wdata[NUM_HEX-1:0];
            event_q <= (event_q & ~event_clr) | key_rise;
        end
    end

    // ---------------- display outputs ----------------
    logic [NUM_HEX-1:0][6:0] seg;

    for (genvar n = 0; n < NUM_HEX; n++) begin : g_seg
        assign seg[n] = blank_q[n] ? SEG_BLANK : seg_decode(hex_q[4*n +: 4]);
    end

    assign hex0 = seg[0];
    assign hex1 = seg[1];
    assign hex2 = seg[2];
    assign hex3 = seg[3];
    assign hex4 = seg[4];
    assign hex5 = seg[5];
    assign led  = led_q;

endmodule
